// File: rtl/frame_bank_pkg.sv
// Shared types and constants for the triple-buffer frame bank scheduler.
package frame_bank_pkg;

    localparam int NUM_BANKS = 3;

    typedef logic [1:0] bank_t;

    localparam bank_t WR_BANK_RST   = 2'd0;
    localparam bank_t RD_BANK_RST   = 2'd1;
    localparam bank_t PEND_BANK_RST = 2'd2;

    // Bank indices 0..NUM_BANKS-1 sum to this, so the third bank is the remainder.
    localparam bank_t BANK_SUM = bank_t'(NUM_BANKS * (NUM_BANKS - 1) / 2);

    typedef enum logic {
        W_IDLE,
        W_ACTIVE
    } wr_state_t;

    function automatic bank_t free_bank(input bank_t a, input bank_t b);
        return bank_t'(BANK_SUM - a - b);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// One-bit registered rising-edge detector; a level held high yields a single pulse.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= din;
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/frame_bank_sched.sv
// Triple-buffer bank scheduler: tracks stream frames and HDMI vsync, and rotates
// writer/reader/pending banks so the reader always shows the newest complete frame.
module frame_bank_sched
    import frame_bank_pkg::*;
#(
    parameter int NUM_LINES = 480,
    parameter int LINE_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_axis_video_tvalid,
    input  logic              s_axis_video_tready,
    input  logic              s_axis_video_tuser,
    input  logic              s_axis_video_tlast,
    input  logic              rd_vsync,
    output bank_t             wr_bank,
    output logic              wr_en,
    output bank_t             rd_bank,
    output logic              frame_ready,
    output logic [LINE_W-1:0] wr_line,
    output logic [15:0]       drop_cnt,
    output logic [15:0]       bad_frame_cnt
);

    wr_state_t         state, state_next;
    logic [LINE_W-1:0] line_next;
    logic              fire, sof, eol;
    logic              restart, complete, vs_rise;
    bank_t             pend_bank;
    logic              pend_valid;

    assign fire = s_axis_video_tvalid & s_axis_video_tready;
    assign sof  = fire & s_axis_video_tuser;
    assign eol  = fire & s_axis_video_tlast;

    // Held in reset, the memory must not see a stray write from a start-of-frame beat.
    assign wr_en = fire & ((state == W_ACTIVE) | s_axis_video_tuser) & ~rst;

    rise_detect u_vsync_rise (
        .clk  (clk),
        .rst  (rst),
        .din  (rd_vsync),
        .rise (vs_rise)
    );

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        line_next  = wr_line;
        restart    = 1'b0;
        complete   = 1'b0;
        case (state)
            W_IDLE: begin
                if (sof) begin
                    state_next = W_ACTIVE;
                    line_next  = '0;
                end
            end
            W_ACTIVE: begin
                if (sof) begin
                    restart   = 1'b1;
                    line_next = '0;
                end else if (eol) begin
                    if (wr_line == LINE_W'(NUM_LINES - 1)) begin
                        complete   = 1'b1;
                        state_next = W_IDLE;
                        line_next  = '0;
                    end else begin
                        line_next = wr_line + LINE_W'(1);
                    end
                end
            end
            default: begin
                state_next = W_IDLE;
                line_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= W_IDLE;
            wr_line <= '0;
        end else begin
            state   <= state_next;
            wr_line <= line_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank       <= WR_BANK_RST;
            rd_bank       <= RD_BANK_RST;
            pend_bank     <= PEND_BANK_RST;
            pend_valid    <= 1'b0;
            frame_ready   <= 1'b0;
            drop_cnt      <= '0;
            bad_frame_cnt <= '0;
        end else begin
            if (complete && vs_rise) begin
                // Just-finished frame goes straight to the reader; the old display bank is reused.
                rd_bank     <= wr_bank;
                wr_bank     <= rd_bank;
                pend_valid  <= 1'b0;
                frame_ready <= 1'b1;
                if (pend_valid) drop_cnt <= sat_inc(drop_cnt);
            end else if (complete) begin
                pend_bank  <= wr_bank;
                pend_valid <= 1'b1;
                if (pend_valid) begin
                    drop_cnt <= sat_inc(drop_cnt);
                    wr_bank  <= pend_bank;
                end else begin
                    wr_bank  <= free_bank(wr_bank, rd_bank);
                end
            end else if (vs_rise && pend_valid) begin
                rd_bank     <= pend_bank;
                pend_valid  <= 1'b0;
                frame_ready <= 1'b1;
            end
            if (restart) bad_frame_cnt <= sat_inc(bad_frame_cnt);
        end
    end

endmodule

// File: tb/tb_frame_bank_sched.sv
// Scoreboard bench for frame_bank_sched with a 4-line frame: the driver queues
// expected beat and state responses, a negedge monitor pops and compares them.
module tb_frame_bank_sched;
    import frame_bank_pkg::*;

    localparam int NL = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          tvalid, tready, tuser, tlast, rd_vsync;
    bank_t         wr_bank, rd_bank;
    logic          wr_en, frame_ready;
    logic [LW-1:0] wr_line;
    logic [15:0]   drop_cnt, bad_frame_cnt;
    logic          probe;

    typedef struct {
        logic  en;
        bank_t wb;
    } beat_exp_t;

    typedef struct {
        bank_t         wb, rb, pb;
        logic          pv, fr, chkp;
        logic [LW-1:0] line;
        logic [15:0]   drop, bad;
    } state_exp_t;

    beat_exp_t  beat_q[$];
    state_exp_t state_q[$];
    beat_exp_t  be;
    state_exp_t se;
    int n_vec = 0;
    int n_err = 0;

    frame_bank_sched #(.NUM_LINES(NL), .LINE_W(LW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_axis_video_tvalid (tvalid),
        .s_axis_video_tready (tready),
        .s_axis_video_tuser  (tuser),
        .s_axis_video_tlast  (tlast),
        .rd_vsync            (rd_vsync),
        .wr_bank             (wr_bank),
        .wr_en               (wr_en),
        .rd_bank             (rd_bank),
        .frame_ready         (frame_ready),
        .wr_line             (wr_line),
        .drop_cnt            (drop_cnt),
        .bad_frame_cnt       (bad_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares whatever the DUT presents, away from the active edge.
    always @(negedge clk) begin
        if (tvalid) begin
            if (beat_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL beat_queue: beat presented with no expectation (t=%0t)", $time);
            end else begin
                be = beat_q.pop_front();
                check("wr_en", wr_en, be.en);
                check("beat_wr_bank", wr_bank, be.wb);
            end
        end
        if (probe) begin
            if (state_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL state_queue: probe with no expectation (t=%0t)", $time);
            end else begin
                se = state_q.pop_front();
                check("wr_bank", wr_bank, se.wb);
                check("rd_bank", rd_bank, se.rb);
                check("pend_valid", dut.pend_valid, se.pv);
                check("frame_ready", frame_ready, se.fr);
                check("wr_line", wr_line, se.line);
                check("drop_cnt", drop_cnt, se.drop);
                check("bad_frame_cnt", bad_frame_cnt, se.bad);
                if (se.chkp) check("pend_bank", dut.pend_bank, se.pb);
            end
        end
        if (!rst) check("bank_invariant", wr_bank != rd_bank, 1);
    end

    task automatic cyc(input logic v, input logic r, input logic u, input logic l);
        @(posedge clk);
        #1;
        tvalid = v;
        tready = r;
        tuser  = u;
        tlast  = l;
        probe  = 1'b0;
    endtask

    task automatic beat(input logic u, input logic l, input logic en, input bank_t wb);
        beat_exp_t b;
        cyc(1'b1, 1'b1, u, l);
        b.en = en;
        b.wb = wb;
        beat_q.push_back(b);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic expect_state(input bank_t wb, input bank_t rb, input bank_t pb,
                                input logic pv, input logic fr, input int line,
                                input int drop, input int bad);
        state_exp_t s;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        probe  = 1'b1;
        s.wb   = wb;
        s.rb   = rb;
        s.pb   = pb;
        s.pv   = pv;
        s.fr   = fr;
        s.chkp = pv;
        s.line = LW'(line);
        s.drop = 16'(drop);
        s.bad  = 16'(bad);
        state_q.push_back(s);
    endtask

    // Reset is raised mid-cycle and probed half a cycle later, before any clock edge.
    task automatic do_reset();
        state_exp_t s;
        @(posedge clk);
        #1;
        rst    = 1'b1;
        tvalid = 1'b0;
        tuser  = 1'b0;
        tlast  = 1'b0;
        probe  = 1'b1;
        s.wb = 2'd0; s.rb = 2'd1; s.pb = 2'd2; s.pv = 1'b0; s.fr = 1'b0; s.chkp = 1'b1;
        s.line = '0; s.drop = '0; s.bad = '0;
        state_q.push_back(s);
        idle(1);
        rst = 1'b0;
    endtask

    task automatic frame(input bank_t wb);
        beat(1'b1, 1'b0, 1'b1, wb);
        beat(1'b0, 1'b0, 1'b1, wb);
        for (int i = 0; i < NL; i++) beat(1'b0, 1'b1, 1'b1, wb);
    endtask

    initial begin
        rst = 1'b1; tvalid = 1'b0; tready = 1'b1; tuser = 1'b0; tlast = 1'b0;
        rd_vsync = 1'b0; probe = 1'b0;
        idle(2);
        do_reset();

        // One frame into bank 0, then handed to the reader on vsync.
        beat(1'b1, 1'b0, 1'b1, 2'd0);
        beat(1'b0, 1'b1, 1'b1, 2'd0);
        beat(1'b0, 1'b1, 1'b1, 2'd0);
        expect_state(2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 2, 0, 0);
        beat(1'b0, 1'b1, 1'b1, 2'd0);
        beat(1'b0, 1'b1, 1'b1, 2'd0);
        expect_state(2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 0, 0, 0);
        rd_vsync = 1'b1;
        expect_state(2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 0, 0, 0);
        rd_vsync = 1'b0;

        // Three frames without vsync: two overwritten pending frames.
        do_reset();
        frame(2'd0);
        expect_state(2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 0, 0, 0);
        frame(2'd2);
        expect_state(2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 0, 1, 0);
        frame(2'd0);
        expect_state(2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 0, 2, 0);
        rd_vsync = 1'b1;
        expect_state(2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 0, 2, 0);
        rd_vsync = 1'b0;

        // Restart after 2 lines with tuser+tlast on the same beat; the new frame completes.
        beat(1'b1, 1'b0, 1'b1, 2'd2);
        beat(1'b0, 1'b1, 1'b1, 2'd2);
        beat(1'b0, 1'b1, 1'b1, 2'd2);
        expect_state(2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 2, 2, 0);
        beat(1'b1, 1'b1, 1'b1, 2'd2);
        expect_state(2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 0, 2, 1);
        for (int i = 0; i < NL; i++) beat(1'b0, 1'b1, 1'b1, 2'd2);
        expect_state(2'd1, 2'd0, 2'd2, 1'b1, 1'b1, 0, 2, 1);

        // Completion and vsync rise on the same edge with nothing pending.
        do_reset();
        beat(1'b1, 1'b0, 1'b1, 2'd0);
        for (int i = 0; i < NL - 1; i++) beat(1'b0, 1'b1, 1'b1, 2'd0);
        beat(1'b0, 1'b1, 1'b1, 2'd0);
        rd_vsync = 1'b1;
        expect_state(2'd1, 2'd0, 2'd0, 1'b0, 1'b1, 0, 0, 0);
        rd_vsync = 1'b0;

        // Beats before the first tuser are discarded; vsync held high swaps once.
        do_reset();
        beat(1'b0, 1'b0, 1'b0, 2'd0);
        beat(1'b0, 1'b1, 1'b0, 2'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        beat_q.push_back('{en: 1'b0, wb: 2'd0});
        expect_state(2'd0, 2'd1, 2'd0, 1'b0, 1'b0, 0, 0, 0);
        frame(2'd0);
        expect_state(2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 0, 0, 0);
        rd_vsync = 1'b1;
        expect_state(2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 0, 0, 0);
        frame(2'd2);
        idle(92);
        expect_state(2'd1, 2'd0, 2'd2, 1'b1, 1'b1, 0, 0, 0);
        rd_vsync = 1'b0;
        idle(2);
        rd_vsync = 1'b1;
        expect_state(2'd1, 2'd2, 2'd2, 1'b0, 1'b1, 0, 0, 0);
        rd_vsync = 1'b0;

        // Reset mid-frame, then a clean frame completes into bank 0.
        beat(1'b1, 1'b0, 1'b1, 2'd1);
        beat(1'b0, 1'b1, 1'b1, 2'd1);
        beat(1'b0, 1'b1, 1'b1, 2'd1);
        expect_state(2'd1, 2'd2, 2'd2, 1'b0, 1'b1, 2, 0, 0);
        do_reset();
        frame(2'd0);
        expect_state(2'd2, 2'd1, 2'd0, 1'b1, 1'b0, 0, 0, 0);

        idle(3);
        n_vec++;
        if (beat_q.size() != 0 || state_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d beat and %0d state expectations left, required 0",
                     beat_q.size(), state_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
